sad_search_driver: RTL and testbench
====================================

// Module: sad_search_driver
// PURPOSE
//  Initiator side of the SAD engine handshake (init/load/loaded/done/ack). Holds one origin block
//  and NUM_CAND candidate blocks in local sample memory. On start, runs one SAD per candidate:
//  pulses init, answers each load with 4+4 samples and a loaded pulse, captures out_sad on done,
//  then acks. Tracks the minimum SAD and its candidate index. Sits beside the SAD top level.
// PARAMETERS
//  WIDTH     8  sample width; SAD result is WIDTH+5 bits
//  BEATS     4  4-sample groups per block (block = 4*BEATS samples)
//  NUM_CAND  4  candidate blocks per search (>=2)
// PORTS
//  clk          in   1            clock, all state on rising edge
//  rst          in   1            async reset, active-low
//  wr_en        in   1            sample write strobe (honoured only in IDLE)
//  wr_sel       in   1            0 = origin mem, 1 = candidate mem
//  wr_addr      in   AW           sample address; origin uses low log2(4*BEATS) bits
//  wr_data      in   WIDTH        sample value
//  start        in   1            1-cycle search request (honoured only in IDLE)
//  init         out  1            1-cycle SAD start pulse
//  load         in   1            SAD requests next beat (level)
//  loaded       out  1            1-cycle: ori_*/can_* valid
//  ori_0..3     out  WIDTH        origin samples of current beat
//  can_0..3     out  WIDTH        candidate samples of current beat
//  done         in   1            SAD result valid (held until ack)
//  out_sad      in   WIDTH+5      SAD result
//  ack          out  1            1-cycle result acknowledge
//  busy         out  1            high from start accepted until search_done
//  search_done  out  1            1-cycle, best_* final
//  best_sad     out  WIDTH+5      minimum SAD of last search
//  best_idx     out  CW           candidate index of best_sad
//  AW = $clog2(4*BEATS*NUM_CAND), CW = $clog2(NUM_CAND)
// BEHAVIOUR
//  Reset: every output 0; FSM IDLE; cand_idx, beat_idx 0; memories not cleared.
//  FSM: IDLE -start-> INIT (init=1, beat_idx<=0) -> WAIT_LOAD
//   WAIT_LOAD: load=1 -> SEND; done=1 -> CAPTURE (done has priority over load)
//   SEND: drive beat beat_idx on ori_*/can_*, loaded=1 one cycle, beat_idx<=beat_idx+1
//         mod BEATS -> WAIT_LOAD (loaded never asserted two consecutive cycles)
//   CAPTURE: ack=1 one cycle; if out_sad<best_sad or cand_idx==0: best_sad<=out_sad,
//         best_idx<=cand_idx (ties keep lower index); last cand -> FINISH else
//         cand_idx++ -> WAIT_ACKDROP
//   WAIT_ACKDROP: wait until done==0 -> INIT for next candidate
//   FINISH: search_done=1 one cycle, busy<=0, cand_idx<=0 -> IDLE
//  Data: ori_k = ori_mem[4*beat_idx+k]; can_k = can_mem[4*BEATS*cand_idx + 4*beat_idx + k];
//   registered, stable from SEND until next SEND. Latency load->loaded = 1 or 2 cycles.
//  Boundaries: start while busy ignored; wr_en outside IDLE ignored (no corruption mid-search);
//   more than BEATS load requests -> beat_idx wraps to 0; wr_en and start same cycle in IDLE ->
//   write completes, search uses new data. Reset mid-search -> IDLE, outputs 0, best_* 0.
//  best_sad/best_idx hold until next search's first CAPTURE.
// STRUCTURE
//  Package sad_pkg: WIDTH default, SAD_W = WIDTH+5, FSM state enum, AW/CW helper functions.
//  Sub-module sad_sample_mem: 1 write port, 4-sample-wide registered read (instantiated twice).
// TESTING
//  1 WIDTH=8,BEATS=4,NUM_CAND=4; SAD model replies out_sad=50,20,30,20 -> best_sad=20,best_idx=1, 4 init,16 loaded,4 ack.
//  2 ori_mem[0..3]=1,2,3,4, can cand2 beat0 = 9,8,7,6 -> at cand2 first loaded ori_*=1..4, can_*=9..6.
//  3 start pulsed during busy and wr_en during search -> ignored, memory contents unchanged.
//  4 model issues 5 loads for one candidate -> 5th loaded returns beat 0 samples.
//  5 rst low during SEND of cand 2 -> all outputs 0 next edge; new start restarts at cand 0.
//  6 done held 3 cycles after ack -> no second ack, next init only after done falls.

Source files
------------

// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared constants, FSM state type and sizing helpers for the SAD search driver
package sad_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int SAD_W     = DEF_WIDTH + 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_WAIT_LOAD,
      S_SEND,
      S_CAPTURE,
      S_WAIT_ACKDROP,
      S_FINISH
   } sad_state_t;

   function automatic int sad_aw(input int beats, input int num_cand);
      return $clog2(4 * beats * num_cand);
   endfunction

   function automatic int sad_cw(input int num_cand);
      return (num_cand < 2) ? 1 : $clog2(num_cand);
   endfunction

   function automatic int sad_bw(input int beats);
      return (beats < 2) ? 1 : $clog2(beats);
   endfunction

endpackage

// File: rtl/sad_sample_mem.sv
// rtl/sad_sample_mem.sv - sample store with one write port and a registered 4-sample group read
module sad_sample_mem #(
   parameter int WIDTH  = 8,
   parameter int GROUPS = 4,
   parameter int AW     = 4,
   parameter int GW     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [GW-1:0]    rd_group,
   output logic [WIDTH-1:0] rd_data_0,
   output logic [WIDTH-1:0] rd_data_1,
   output logic [WIDTH-1:0] rd_data_2,
   output logic [WIDTH-1:0] rd_data_3
);

   localparam int DEPTH = 4 * GROUPS;

   logic [WIDTH-1:0]          mem_q [DEPTH];
   logic [3:0][WIDTH-1:0]     rd_q;
   logic [3:0][WIDTH-1:0]     rd_d;
   logic [AW-1:0]             base;

   // Sample storage is deliberately left out of reset so contents survive a search abort.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign base = AW'(rd_group) << 2;

   always_comb begin
      rd_d = rd_q;
      if (rd_en) begin
         for (int k = 0; k < 4; k++) begin
            rd_d[k] = mem_q[base + AW'(k)];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

   assign rd_data_0 = rd_q[0];
   assign rd_data_1 = rd_q[1];
   assign rd_data_2 = rd_q[2];
   assign rd_data_3 = rd_q[3];

endmodule

// File: rtl/sad_search_driver.sv
// rtl/sad_search_driver.sv - initiator for the SAD engine handshake; runs one SAD per candidate
// block and tracks the minimum result and its candidate index.
module sad_search_driver
   import sad_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int BEATS    = 4,
   parameter int NUM_CAND = 4,
   localparam int AW      = sad_aw(BEATS, NUM_CAND),
   localparam int CW      = sad_cw(NUM_CAND)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             wr_sel,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   output logic             init,
   input  logic             load,
   output logic             loaded,
   output logic [WIDTH-1:0] ori_0,
   output logic [WIDTH-1:0] ori_1,
   output logic [WIDTH-1:0] ori_2,
   output logic [WIDTH-1:0] ori_3,
   output logic [WIDTH-1:0] can_0,
   output logic [WIDTH-1:0] can_1,
   output logic [WIDTH-1:0] can_2,
   output logic [WIDTH-1:0] can_3,
   input  logic             done,
   input  logic [WIDTH+4:0] out_sad,
   output logic             ack,
   output logic             busy,
   output logic             search_done,
   output logic [WIDTH+4:0] best_sad,
   output logic [CW-1:0]    best_idx
);

   localparam int SW  = WIDTH + 5;
   localparam int BW  = sad_bw(BEATS);
   localparam int OAW = $clog2(4 * BEATS);
   localparam int CGW = AW - 2;

   sad_state_t     state_q, state_d;
   logic [BW-1:0]  beat_idx_q, beat_idx_d;
   logic [CW-1:0]  cand_idx_q, cand_idx_d;
   logic [CW-1:0]  best_idx_q, best_idx_d;
   logic [SW-1:0]  best_sad_q, best_sad_d;
   logic           in_idle;
   logic           last_cand;
   logic           last_beat;
   logic           rd_en;
   logic [CGW-1:0] can_group;

   assign in_idle   = (state_q == S_IDLE);
   assign last_cand = (cand_idx_q == CW'(NUM_CAND - 1));
   assign last_beat = (beat_idx_q == BW'(BEATS - 1));
   // Beat registers load on the edge into SEND, so ori_*/can_* hold until the next SEND.
   assign rd_en     = (state_q == S_WAIT_LOAD) && load && !done;
   assign can_group = CGW'(cand_idx_q) * CGW'(BEATS) + CGW'(beat_idx_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:         if (start) state_d = S_INIT;
         S_INIT:         state_d = S_WAIT_LOAD;
         S_WAIT_LOAD: begin
            if (done) begin
               state_d = S_CAPTURE;
            end else if (load) begin
               state_d = S_SEND;
            end
         end
         S_SEND:         state_d = S_WAIT_LOAD;
         S_CAPTURE:      state_d = last_cand ? S_FINISH : S_WAIT_ACKDROP;
         S_WAIT_ACKDROP: if (!done) state_d = S_INIT;
         S_FINISH:       state_d = S_IDLE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      init        = 1'b0;
      loaded      = 1'b0;
      ack         = 1'b0;
      search_done = 1'b0;
      busy        = 1'b1;
      case (state_q)
         S_IDLE:    busy        = 1'b0;
         S_INIT:    init        = 1'b1;
         S_SEND:    loaded      = 1'b1;
         S_CAPTURE: ack         = 1'b1;
         S_FINISH:  search_done = 1'b1;
         default:   ;
      endcase
   end

   always_comb begin
      beat_idx_d = beat_idx_q;
      cand_idx_d = cand_idx_q;
      best_sad_d = best_sad_q;
      best_idx_d = best_idx_q;
      case (state_q)
         S_INIT: beat_idx_d = '0;
         S_SEND: beat_idx_d = last_beat ? '0 : beat_idx_q + 1'b1;
         S_CAPTURE: begin
            // Strict less-than keeps the lower index on ties; candidate 0 always seeds the minimum.
            if ((out_sad < best_sad_q) || (cand_idx_q == '0)) begin
               best_sad_d = out_sad;
               best_idx_d = cand_idx_q;
            end
            if (!last_cand) begin
               cand_idx_d = cand_idx_q + 1'b1;
            end
         end
         S_FINISH: cand_idx_d = '0;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_idx_q <= '0;
         cand_idx_q <= '0;
         best_sad_q <= '0;
         best_idx_q <= '0;
      end else begin
         beat_idx_q <= beat_idx_d;
         cand_idx_q <= cand_idx_d;
         best_sad_q <= best_sad_d;
         best_idx_q <= best_idx_d;
      end
   end

   assign best_sad = best_sad_q;
   assign best_idx = best_idx_q;

   sad_sample_mem #(
      .WIDTH  (WIDTH),
      .GROUPS (BEATS),
      .AW     (OAW),
      .GW     (BW)
   ) u_ori_mem (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en && !wr_sel && in_idle),
      .wr_addr   (wr_addr[OAW-1:0]),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_group  (beat_idx_q),
      .rd_data_0 (ori_0),
      .rd_data_1 (ori_1),
      .rd_data_2 (ori_2),
      .rd_data_3 (ori_3)
   );

   sad_sample_mem #(
      .WIDTH  (WIDTH),
      .GROUPS (BEATS * NUM_CAND),
      .AW     (AW),
      .GW     (CGW)
   ) u_can_mem (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en && wr_sel && in_idle),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_group  (can_group),
      .rd_data_0 (can_0),
      .rd_data_1 (can_1),
      .rd_data_2 (can_2),
      .rd_data_3 (can_3)
   );

endmodule

// File: tb/tb_sad_search_driver.sv
// tb/tb_sad_search_driver.sv - directed table-driven bench for sad_search_driver with a
// behavioural SAD-engine responder.
module tb_sad_search_driver;

   localparam int WIDTH    = 8;
   localparam int BEATS    = 4;
   localparam int NUM_CAND = 4;
   localparam int SW       = WIDTH + 5;
   localparam int AW       = $clog2(4 * BEATS * NUM_CAND);
   localparam int CW       = $clog2(NUM_CAND);
   localparam int OSZ      = 4 * BEATS;
   localparam int CSZ      = 4 * BEATS * NUM_CAND;
   localparam int NVEC     = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             wr_en = 1'b0;
   logic             wr_sel = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             start = 1'b0;
   logic             load = 1'b0;
   logic             done = 1'b0;
   logic [SW-1:0]    out_sad = '0;
   logic             init, loaded, ack, busy, search_done;
   logic [WIDTH-1:0] ori_0, ori_1, ori_2, ori_3;
   logic [WIDTH-1:0] can_0, can_1, can_2, can_3;
   logic [SW-1:0]    best_sad;
   logic [CW-1:0]    best_idx;

   always #5 clk = ~clk;

   sad_search_driver #(
      .WIDTH    (WIDTH),
      .BEATS    (BEATS),
      .NUM_CAND (NUM_CAND)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_sel      (wr_sel),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .start       (start),
      .init        (init),
      .load        (load),
      .loaded      (loaded),
      .ori_0       (ori_0),
      .ori_1       (ori_1),
      .ori_2       (ori_2),
      .ori_3       (ori_3),
      .can_0       (can_0),
      .can_1       (can_1),
      .can_2       (can_2),
      .can_3       (can_3),
      .done        (done),
      .out_sad     (out_sad),
      .ack         (ack),
      .busy        (busy),
      .search_done (search_done),
      .best_sad    (best_sad),
      .best_idx    (best_idx)
   );

   typedef struct packed {
      logic [3:0][SW-1:0] sad;
      logic [SW-1:0]      exp_sad;
      logic [CW-1:0]      exp_idx;
   } vec_t;

   vec_t             vecs [NVEC];
   int               n_vec = 0;
   int               n_bad = 0;
   int               n_init = 0;
   int               n_loaded = 0;
   int               n_ack = 0;
   int               n_sdone = 0;
   logic             loaded_prev = 1'b0;
   logic [WIDTH-1:0] ori_ref [OSZ];
   logic [WIDTH-1:0] can_ref [CSZ];
   logic [WIDTH-1:0] first_ori [NUM_CAND][4];
   logic [WIDTH-1:0] first_can [NUM_CAND][4];
   logic [WIDTH-1:0] wrap_ori [4];
   logic [WIDTH-1:0] wrap_can [4];
   logic [SW-1:0]    cur_sad [NUM_CAND];
   int               cur_nloads [NUM_CAND];
   int               cur_hold [NUM_CAND];
   int               abort_cand = -1;
   bit               inject = 1'b0;
   bit               aborted = 1'b0;
   bit               pend_wr = 1'b0;
   int               pend_addr = 0;
   logic [WIDTH-1:0] pend_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (init)        n_init++;
         if (ack)         n_ack++;
         if (search_done) n_sdone++;
         if (loaded) begin
            n_loaded++;
            check("loaded_back_to_back", 32'(loaded_prev), 32'd0);
         end
         loaded_prev = loaded;
      end else begin
         loaded_prev = 1'b0;
      end
   end

   function automatic logic sel_sig(input int w);
      case (w)
         0:       return init;
         1:       return loaded;
         2:       return ack;
         default: return search_done;
      endcase
   endfunction

   task automatic wait_for(input int w, input string name);
      int t = 0;
      while (!sel_sig(w) && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!sel_sig(w)) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: timeout after %0d cycles, required 1", name, t);
      end
   endtask

   task automatic mem_wr(input logic sel, input int addr, input logic [WIDTH-1:0] data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = AW'(addr);
      wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
      if (sel) can_ref[addr] = data;
      else     ori_ref[addr] = data;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_init"}, 32'(init), 0);
      check({tag, "_loaded"}, 32'(loaded), 0);
      check({tag, "_ack"}, 32'(ack), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_search_done"}, 32'(search_done), 0);
      check({tag, "_best_sad"}, 32'(best_sad), 0);
      check({tag, "_best_idx"}, 32'(best_idx), 0);
      check({tag, "_ori"}, {ori_0, ori_1, ori_2, ori_3}, 0);
      check({tag, "_can"}, {can_0, can_1, can_2, can_3}, 0);
   endtask

   task automatic run_cand(input int c);
      logic [WIDTH-1:0] o [4];
      logic [WIDTH-1:0] cv [4];
      int b;
      wait_for(0, $sformatf("init_wait_c%0d", c));
      if (inject && c == 1) begin
         start   = 1'b1;
         wr_en   = 1'b1;
         wr_sel  = 1'b1;
         wr_addr = AW'(32);
         wr_data = 8'hEE;
         @(negedge clk);
         wr_sel  = 1'b0;
         wr_addr = '0;
         @(negedge clk);
         start = 1'b0;
         wr_en = 1'b0;
      end
      for (int i = 0; i < cur_nloads[c]; i++) begin
         load = 1'b1;
         @(negedge clk);
         wait_for(1, $sformatf("loaded_wait_c%0d_l%0d", c, i));
         load = 1'b0;
         o  = '{ori_0, ori_1, ori_2, ori_3};
         cv = '{can_0, can_1, can_2, can_3};
         b  = i % BEATS;
         for (int k = 0; k < 4; k++) begin
            check($sformatf("ori_c%0d_l%0d_k%0d", c, i, k), 32'(o[k]), 32'(ori_ref[4*b + k]));
            check($sformatf("can_c%0d_l%0d_k%0d", c, i, k), 32'(cv[k]),
                  32'(can_ref[4*BEATS*c + 4*b + k]));
            if (i == 0) begin
               first_ori[c][k] = o[k];
               first_can[c][k] = cv[k];
            end
            if (i == BEATS) begin
               wrap_ori[k] = o[k];
               wrap_can[k] = cv[k];
            end
         end
         if (c == abort_cand) begin
            rst = 1'b0;
            #1;
            check_zero("abort_async");
            @(negedge clk);
            check_zero("abort_edge");
            load    = 1'b0;
            done    = 1'b0;
            rst     = 1'b1;
            aborted = 1'b1;
            return;
         end
      end
      out_sad = cur_sad[c];
      done    = 1'b1;
      @(negedge clk);
      wait_for(2, $sformatf("ack_wait_c%0d", c));
      for (int h = 0; h < cur_hold[c]; h++) begin
         @(negedge clk);
         check($sformatf("no_reack_c%0d_h%0d", c, h), 32'(ack), 0);
         check($sformatf("no_init_done_high_c%0d_h%0d", c, h), 32'(init), 0);
      end
      done = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_search(input string tag, input logic [SW-1:0] exp_sad,
                             input int exp_idx, input int exp_loaded);
      int i0, l0, a0;
      i0 = n_init;
      l0 = n_loaded;
      a0 = n_ack;
      aborted = 1'b0;
      if (pend_wr) begin
         wr_en   = 1'b1;
         wr_sel  = 1'b0;
         wr_addr = AW'(pend_addr);
         wr_data = pend_data;
         ori_ref[pend_addr] = pend_data;
         pend_wr = 1'b0;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      check({tag, "_busy_after_start"}, 32'(busy), 1);
      for (int c = 0; c < NUM_CAND && !aborted; c++) begin
         run_cand(c);
      end
      if (aborted) return;
      wait_for(3, {tag, "_search_done_wait"});
      check({tag, "_best_sad"}, 32'(best_sad), 32'(exp_sad));
      check({tag, "_best_idx"}, 32'(best_idx), 32'(exp_idx));
      check({tag, "_busy_at_done"}, 32'(busy), 1);
      @(negedge clk);
      check({tag, "_busy_after"}, 32'(busy), 0);
      check({tag, "_search_done_pulse"}, 32'(search_done), 0);
      check({tag, "_best_sad_hold"}, 32'(best_sad), 32'(exp_sad));
      check({tag, "_n_init"}, 32'(n_init - i0), NUM_CAND);
      check({tag, "_n_loaded"}, 32'(n_loaded - l0), 32'(exp_loaded));
      check({tag, "_n_ack"}, 32'(n_ack - a0), NUM_CAND);
   endtask

   task automatic set_vec(input int v, input int s0, input int s1, input int s2, input int s3,
                          input int es, input int ei);
      vecs[v].sad[0]  = SW'(s0);
      vecs[v].sad[1]  = SW'(s1);
      vecs[v].sad[2]  = SW'(s2);
      vecs[v].sad[3]  = SW'(s3);
      vecs[v].exp_sad = SW'(es);
      vecs[v].exp_idx = CW'(ei);
   endtask

   task automatic plain_cfg();
      for (int c = 0; c < NUM_CAND; c++) begin
         cur_nloads[c] = BEATS;
         cur_hold[c]   = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s0;
      set_vec(0,   50,   20,   30,   20,   20, 1);
      set_vec(1,   10,   10,   10,   10,   10, 0);
      set_vec(2,  100,   90,   80,    5,    5, 3);
      set_vec(3,    0,    1,    2,    3,    0, 0);
      set_vec(4, 8191, 8190, 8191, 8191, 8190, 1);

      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < OSZ; i++) mem_wr(1'b0, i, WIDTH'(i + 1));
      for (int j = 0; j < CSZ; j++) mem_wr(1'b1, j, WIDTH'((j * 7 + 3) % 256));
      for (int k = 0; k < 4; k++)   mem_wr(1'b1, 4*BEATS*2 + k, WIDTH'(9 - k));

      for (int v = 0; v < NVEC; v++) begin
         plain_cfg();
         for (int c = 0; c < NUM_CAND; c++) cur_sad[c] = vecs[v].sad[c];
         run_search($sformatf("vec%0d", v), vecs[v].exp_sad, int'(vecs[v].exp_idx), NUM_CAND*BEATS);
         if (v == 0) begin
            for (int k = 0; k < 4; k++) begin
               check($sformatf("cand2_first_ori_k%0d", k), 32'(first_ori[2][k]), 32'(k + 1));
               check($sformatf("cand2_first_can_k%0d", k), 32'(first_can[2][k]), 32'(9 - k));
            end
         end
         repeat (2) @(negedge clk);
      end

      // Extra load, held done, writes/start during busy, and a write coinciding with start.
      plain_cfg();
      cur_nloads[0] = BEATS + 1;
      cur_hold[1]   = 3;
      cur_sad[0] = SW'(40);
      cur_sad[1] = SW'(30);
      cur_sad[2] = SW'(60);
      cur_sad[3] = SW'(70);
      inject    = 1'b1;
      pend_wr   = 1'b1;
      pend_addr = 5;
      pend_data = 8'h55;
      s0 = n_sdone;
      run_search("corner", SW'(30), 1, NUM_CAND*BEATS + 1);
      inject = 1'b0;
      check("corner_one_search_done", 32'(n_sdone - s0), 1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("wrap_ori_k%0d", k), 32'(wrap_ori[k]), 32'(k + 1));
         check($sformatf("wrap_can_k%0d", k), 32'(wrap_can[k]), 32'(7 * k + 3));
         check($sformatf("busy_wr_ori_k%0d", k), 32'(first_ori[2][k]), 32'(k + 1));
         check($sformatf("busy_wr_can_k%0d", k), 32'(first_can[2][k]), 32'(9 - k));
      end
      repeat (2) @(negedge clk);

      // Reset while candidate 2 is being sent, then a full restart.
      plain_cfg();
      cur_sad[0] = SW'(50);
      cur_sad[1] = SW'(20);
      cur_sad[2] = SW'(30);
      cur_sad[3] = SW'(20);
      abort_cand = 2;
      run_search("abort", SW'(20), 1, NUM_CAND*BEATS);
      check("abort_taken", 32'(aborted), 1);
      abort_cand = -1;
      @(negedge clk);
      cur_sad[0] = SW'(25);
      cur_sad[1] = SW'(35);
      cur_sad[2] = SW'(15);
      cur_sad[3] = SW'(45);
      run_search("restart", SW'(15), 2, NUM_CAND*BEATS);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
